regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port rd_addr  input  NRD*AW  packed read addresses, port r at [r*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRD*XLEN  packed read data, port r at [r*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRD  scoreboard busy flag of each read address.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*AW  packed write addresses.
REQ-012 SHALL have port wr_data  input  NWR*XLEN  packed write data.
REQ-013 SHALL have port iss_en  input  1  issue strobe: marks iss_addr as pending writeback.
REQ-014 SHALL have port iss_addr  input  AW  destination register being issued.

Function
REQ-015 Register 0 SHALL read as 0, never be written, never be busy.
REQ-016 Write: on clk edge with rst low, each port w with wr_en[w]=1 and wr_addr!=0 SHALL store wr_data into regs[wr_addr].
REQ-017 Write conflict (two ports, same address, same cycle): highest-index port SHALL win.
REQ-018 Read SHALL be combinational, zero-cycle latency: rd_data[r] = regs[rd_addr[r]].
REQ-019 Bypass: if any enabled write port targets rd_addr[r] (!=0) in the current cycle, rd_data[r] SHALL return that write's data (highest-index matching port), i.e. write-first.
REQ-020 Scoreboard: busy[NREGS] bit vector; iss_en=1 with iss_addr!=0 SHALL set busy[iss_addr] at next edge.
REQ-021 Any enabled write to address a SHALL clear busy[a] at next edge.
REQ-022 Issue and write to same address in same cycle: set SHALL win (newer producer), busy[a]=1 after edge.
REQ-023 rd_busy[r] SHALL equal busy[rd_addr[r]] AND NOT (enabled write to rd_addr[r] this cycle); a same-cycle issue SHALL NOT be visible until the next cycle.
REQ-024 Writes, issues and reads to address 0 SHALL be ignored / return 0 / not busy regardless of other inputs.
REQ-025 Read addresses SHALL be independent; all NRD ports may address the same register.

Reset
REQ-026 While rst=1 at a clk edge, all registers and all busy bits SHALL clear to 0; writes and issues that cycle SHALL be discarded.
REQ-027 While rst=1, rd_data SHALL be all-zero and rd_busy all-zero (bypass suppressed).
REQ-028 rst asserted mid-operation SHALL override any pending write/issue; first accepted write is the first edge with rst=0.
REQ-029 No initial blocks SHALL be relied on for state; reset is the only initialisation.

Structure
REQ-030 Package regfile_pkg SHALL hold XLEN/NREGS defaults, AW computation function, and reg address/data typedefs, shared with pipeline stages.
REQ-031 Storage and write logic SHALL be a single clocked process; read/bypass combinational per port.
REQ-032 One sub-module, regfile_scoreboard (busy vector, set/clear priority, busy lookup), is natural; instantiate once.

Verification
REQ-033 Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0.
REQ-034 wr_en=01, wr_addr[0]=5, wr_data[0]=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF (bypass); next cycle rd_addr[1]=5 -> 0xDEADBEEF from storage.
REQ-035 Both write ports to addr 7, data 0x11 (port0) and 0x22 (port1) -> bypass and subsequent read return 0x22.
REQ-036 Write 0xFFFFFFFF to addr 0 with iss_en to addr 0 -> read addr 0 returns 0, rd_busy=0.
REQ-037 iss_en addr 9 -> next cycle rd_busy=1 for addr 9; write addr 9 with 0x1234 -> rd_busy=0 same cycle, data 0x1234; issue+write addr 9 same cycle -> busy=1 next cycle.
REQ-038 Write 0xA5A5A5A5 to addr 3, assert rst for one cycle with concurrent write to addr 4 -> after reset addr 3 and 4 read 0, no busy bits set.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, address-width helper and
// address/data types used by the pipeline stages around the register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // A one-entry file would give a zero-width address, so floor the width at 1.
    function automatic int calc_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = calc_aw(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-ported register file: packed read, write and issue
// signals. Clock and reset stay as plain ports on the modules.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = calc_aw(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, issue sets and
// writeback clears, with a write-through busy lookup for each read port.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;

    // Issue is applied after the clears so a newer producer keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) busy[wr_addr[w*AW +: AW]] <= 1'b0;
            end
            if (iss_en && (iss_addr != '0)) busy[iss_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            logic [AW-1:0] ra;
            logic          hit;
            ra  = rd_addr[r*AW +: AW];
            hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) hit = 1'b1;
            end
            rd_busy[r] = !rst && (ra != '0) && busy[ra] && !hit;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-first bypass and a pending-writeback
// scoreboard; register 0 is hardwired to zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = calc_aw(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] != '0))
                    regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = bus.rd_addr[r*AW +: AW];

        always_comb begin
            rv = regs[ra];
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == ra))
                    rv = bus.wr_data[w*XLEN +: XLEN];
            end
            if (rst || (ra == '0)) rv = '0;
        end

        assign bus.rd_data[r*XLEN +: XLEN] = rv;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sweep, table of single-cycle vectors,
// and a mid-operation reset sequence.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [1:0]  wr_en;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        bit          iss_en;
        logic [4:0]  iss_a;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        bit          eb0;
        bit          eb1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector between edges, check the combinational outputs, then let the edge pass.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst          = v.rst;
        bus.wr_en    = v.wr_en;
        bus.wr_addr  = {v.wa1, v.wa0};
        bus.wr_data  = {v.wd1, v.wd0};
        bus.iss_en   = v.iss_en;
        bus.iss_addr = v.iss_a;
        bus.rd_addr  = {v.ra1, v.ra0};
        #1;
        check({tag, ".d0"}, bus.rd_data[31:0],  v.ed0);
        check({tag, ".d1"}, bus.rd_data[63:32], v.ed1);
        check({tag, ".b0"}, {31'd0, bus.rd_busy[0]}, {31'd0, v.eb0});
        check({tag, ".b1"}, {31'd0, bus.rd_busy[1]}, {31'd0, v.eb1});
    endtask

    function automatic vec_t mk(bit r, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, bit ie, logic [4:0] ia,
                                logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                                logic [31:0] ed1, bit eb0, bit eb1);
        vec_t v;
        v = '{r, we, wa0, wd0, wa1, wd1, ie, ia, ra0, ra1, ed0, ed1, eb0, eb1};
        return v;
    endfunction

    initial begin
        rst          = 1'b1;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.rd_addr  = '0;

        // Reset cycle with a write and issue that must be discarded and not bypassed.
        apply(mk(1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0), "rst_wr");
        apply(mk(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0, 0), "rst_hold");

        for (int a = 0; a < NREGS; a++) begin
            apply(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'(a), 5'(NREGS-1-a), 0, 0, 0, 0),
                  $sformatf("sweep%0d", a));
        end

        //                rst we     wa0    wd0            wa1    wd1            ie ia     ra0    ra1    ed0            ed1            eb0 eb1
        vecs.push_back(mk(0, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,         0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,         0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd5,  32'h0,        5'd5,  32'h1,         0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(0, 2'b11, 5'd7,  32'h11,       5'd7,  32'h22,        0, 5'd0,  5'd7,  5'd7,  32'h22,       32'h22,        0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd5,  32'h22,       32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(0, 2'b11, 5'd10, 32'hAAAA,     5'd11, 32'hBBBB,      0, 5'd0,  5'd10, 5'd11, 32'hAAAA,     32'hBBBB,      0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd11, 5'd10, 32'hBBBB,     32'hAAAA,      0, 0));
        vecs.push_back(mk(0, 2'b11, 5'd0,  32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF,  1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,         0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,         0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,         0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd9,  5'd5,  32'h0,        32'hDEADBEEF,  1, 0));
        vecs.push_back(mk(0, 2'b10, 5'd0,  32'h0,        5'd9,  32'h1234,      0, 5'd0,  5'd9,  5'd9,  32'h1234,     32'h1234,      0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         0, 5'd0,  5'd9,  5'd0,  32'h1234,     32'h0,         0, 0));
        vecs.push_back(mk(0, 2'b01, 5'd9,  32'h5678,     5'd0,  32'h0,         1, 5'd9,  5'd9,  5'd9,  32'h5678,     32'h5678,      0, 0));
        vecs.push_back(mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         1, 5'd12, 5'd9,  5'd12, 32'h5678,     32'h0,         1, 0));
        vecs.push_back(mk(0, 2'b01, 5'd3,  32'hA5A5A5A5, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd12, 32'hA5A5A5A5, 32'h0,         0, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Mid-operation reset: concurrent write to 4 and issue to 13 must be lost.
        apply(mk(1, 2'b01, 5'd4, 32'hCAFEF00D, 5'd0, 32'h0, 1, 5'd13, 5'd4, 5'd3, 0, 0, 0, 0), "mid_rst");
        apply(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd4, 0, 0, 0, 0), "post_rst_a");
        apply(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd12, 0, 0, 0, 0), "post_rst_b");
        apply(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd13, 5'd7, 0, 0, 0, 0), "post_rst_c");
        // First write after reset is accepted.
        apply(mk(0, 2'b10, 5'd0, 32'h0, 5'd4, 32'h4444, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), "post_rst_wr");
        apply(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd3, 32'h4444, 0, 0, 0), "post_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
